// File: rtl/seq_add_pkg.sv
// Shared types and default sizing for the sequential-adder operand dispatcher.
package seq_add_pkg;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_e;

    localparam int DEF_WIDTH   = 32;
    localparam int DEF_DEPTH   = 4;
    localparam int DEF_TIMEOUT = 15;

endpackage

// File: rtl/seq_add_dispatch_if.sv
// Producer, adder and consumer handshakes of the dispatcher, bundled as one bus.
interface seq_add_dispatch_if #(parameter int WIDTH = 32);

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic             add_start;
    logic [WIDTH-1:0] add_a;
    logic [WIDTH-1:0] add_b;
    logic [WIDTH-1:0] add_res;
    logic             add_overflow;
    logic             add_ready;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_res;
    logic             out_overflow;

    // master: the dispatcher; slave: producer, adder and consumer around it
    modport master (
        input  in_valid, in_a, in_b, add_res, add_overflow, add_ready, out_ready,
        output in_ready, add_start, add_a, add_b, out_valid, out_res, out_overflow
    );
    modport slave (
        output in_valid, in_a, in_b, add_res, add_overflow, add_ready, out_ready,
        input  in_ready, add_start, add_a, add_b, out_valid, out_res, out_overflow
    );

endinterface

// File: rtl/seq_add_dispatch_fifo.sv
// Power-of-two circular FIFO with occupancy count; head entry visible combinationally.
module sync_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push_i,
    input  logic                   pop_i,
    input  logic [WIDTH-1:0]       din_i,
    output logic [WIDTH-1:0]       head_o,
    output logic [$clog2(DEPTH):0] count_o
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_q, rd_q;
    logic [AW:0]      cnt_q, cnt_d;

    // Storage needs no reset: the head is only consumed while count is nonzero.
    always_ff @(posedge clk) begin
        if (push_i) mem_q[wr_q] <= din_i;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (push_i) wr_q <= wr_q + AW'(1);
            if (pop_i)  rd_q <= rd_q + AW'(1);
            cnt_q <= cnt_d;
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        case ({push_i, pop_i})
            2'b10:   cnt_d = cnt_q + (AW+1)'(1);
            2'b01:   cnt_d = cnt_q - (AW+1)'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    assign head_o  = mem_q[rd_q];
    assign count_o = cnt_q;

endmodule

// File: rtl/seq_add_dispatch.sv
// Queues operand pairs, issues one at a time to a sequential adder, holds each result
// for the consumer and raises a sticky error if the adder never answers.
module seq_add_dispatch
    import seq_add_pkg::*;
#(
    parameter int WIDTH   = DEF_WIDTH,
    parameter int DEPTH   = DEF_DEPTH,
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic                   clk,
    input  logic                   rst,
    seq_add_dispatch_if.master     bus,
    output logic [$clog2(DEPTH):0] count,
    output logic                   err
);
    localparam int CW  = $clog2(DEPTH) + 1;
    localparam int WCW = $clog2(TIMEOUT + 1);

    state_e           state_q, state_d;
    logic [WCW-1:0]   wcnt_q, wcnt_d;
    logic [WIDTH-1:0] opa_q, opb_q;
    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] out_res_q, out_res_d;
    logic             out_ovf_q, out_ovf_d;
    logic             err_q, err_d;
    logic             in_ready, push, pop, issue, capture, timeout;
    logic [2*WIDTH-1:0] head;
    logic [CW-1:0]    fifo_cnt;

    assign in_ready = (fifo_cnt != CW'(DEPTH));
    assign push     = bus.in_valid && in_ready;

    sync_fifo #(.WIDTH(2*WIDTH), .DEPTH(DEPTH)) u_fifo (
        .clk(clk), .rst(rst), .push_i(push), .pop_i(pop),
        .din_i({bus.in_a, bus.in_b}), .head_o(head), .count_o(fifo_cnt)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            wcnt_q      <= '0;
            opa_q       <= '0;
            opb_q       <= '0;
            out_valid_q <= 1'b0;
            out_res_q   <= '0;
            out_ovf_q   <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            wcnt_q      <= wcnt_d;
            if (issue) {opa_q, opb_q} <= head;
            out_valid_q <= out_valid_d;
            out_res_q   <= out_res_d;
            out_ovf_q   <= out_ovf_d;
            err_q       <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        wcnt_d  = wcnt_q;
        issue   = 1'b0;
        pop     = 1'b0;
        capture = 1'b0;
        timeout = 1'b0;
        case (state_q)
            // An unaccepted result blocks issue, so a capture never overwrites it.
            IDLE:  if (fifo_cnt != '0 && (!out_valid_q || bus.out_ready)) state_d = ISSUE;
            ISSUE: begin
                issue   = 1'b1;
                pop     = 1'b1;
                wcnt_d  = '0;
                state_d = WAIT;
            end
            WAIT: begin
                if (bus.add_ready) begin
                    capture = 1'b1;
                    state_d = IDLE;
                end else if (wcnt_q == WCW'(TIMEOUT - 1)) begin
                    timeout = 1'b1;
                    state_d = IDLE;
                end else begin
                    wcnt_d = wcnt_q + WCW'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        out_valid_d = out_valid_q;
        if (capture)                        out_valid_d = 1'b1;
        else if (out_valid_q && bus.out_ready) out_valid_d = 1'b0;
        out_res_d = capture ? bus.add_res      : out_res_q;
        out_ovf_d = capture ? bus.add_overflow : out_ovf_q;
        err_d     = err_q | timeout;
    end

    assign bus.in_ready     = in_ready;
    assign bus.add_start    = issue;
    assign bus.add_a        = issue ? head[2*WIDTH-1:WIDTH] : opa_q;
    assign bus.add_b        = issue ? head[WIDTH-1:0]       : opb_q;
    assign bus.out_valid    = out_valid_q;
    assign bus.out_res      = out_res_q;
    assign bus.out_overflow = out_ovf_q;
    assign count            = fifo_cnt;
    assign err              = err_q;

endmodule

// File: tb/tb_seq_add_dispatch.sv
// Directed bench for seq_add_dispatch with a 5-cycle sequential-adder model.
module tb_seq_add_dispatch;

    logic clk = 1'b0;
    logic rst;
    logic [2:0] count;
    logic err;
    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    seq_add_dispatch_if #(.WIDTH(32)) bus();

    seq_add_dispatch #(.WIDTH(32), .DEPTH(4), .TIMEOUT(15)) dut (
        .clk(clk), .rst(rst), .bus(bus), .count(count), .err(err)
    );

    // Adder model: ready pulses 5 cycles after the start pulse unless hung.
    logic [31:0] ma, mb;
    logic [2:0]  mcnt;
    logic        mbusy;
    logic        hang, spur;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ma <= '0; mb <= '0; mcnt <= '0; mbusy <= 1'b0;
        end else if (bus.add_start && !hang) begin
            ma <= bus.add_a; mb <= bus.add_b; mcnt <= 3'd4; mbusy <= 1'b1;
        end else if (mbusy) begin
            if (mcnt == 3'd0) mbusy <= 1'b0;
            else              mcnt  <= mcnt - 3'd1;
        end
    end

    assign bus.add_ready = (mbusy && mcnt == 3'd0) || spur;
    assign {bus.add_overflow, bus.add_res} = {1'b0, ma} + {1'b0, mb};

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_result(input string tag, input logic [31:0] r, input logic o);
        int n = 0;
        while (!bus.out_valid && n < 40) begin step(); n++; end
        chk({tag, "_valid"}, bus.out_valid, 1);
        chk({tag, "_res"}, bus.out_res, r);
        chk({tag, "_ovf"}, bus.out_overflow, o);
        step();
    endtask

    // Accept in c0, check add_start in c2 and result in c8 exactly.
    task automatic single_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                             input logic [31:0] r, input logic o);
        bus.in_valid = 1'b1; bus.in_a = a; bus.in_b = b;
        step();
        bus.in_valid = 1'b0;
        chk({tag, "_c1_count"}, count, 1);
        chk({tag, "_c1_start"}, bus.add_start, 0);
        step();
        chk({tag, "_c2_start"}, bus.add_start, 1);
        chk({tag, "_c2_a"}, bus.add_a, a);
        chk({tag, "_c2_b"}, bus.add_b, b);
        repeat (5) step();
        chk({tag, "_c7_valid"}, bus.out_valid, 0);
        chk({tag, "_c7_hold_a"}, bus.add_a, a);
        step();
        chk({tag, "_c8_valid"}, bus.out_valid, 1);
        chk({tag, "_c8_res"}, bus.out_res, r);
        chk({tag, "_c8_ovf"}, bus.out_overflow, o);
        step();
        chk({tag, "_c9_valid"}, bus.out_valid, 0);
    endtask

    logic [31:0] ta [6] = '{32'h00000001, 32'h80000000, 32'hFFFFFFFF, 32'h0000FFFF, 32'h7FFFFFFF, 32'hAAAAAAAA};
    logic [31:0] tb_ [6] = '{32'h00000002, 32'h80000000, 32'hFFFFFFFF, 32'h00000001, 32'h00000001, 32'h55555555};
    logic [31:0] tr [6] = '{32'h00000003, 32'h00000000, 32'hFFFFFFFE, 32'h00010000, 32'h80000000, 32'hFFFFFFFF};
    logic        to [6] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    logic [31:0] qa [3] = '{32'd5, 32'd10, 32'd100};
    logic [31:0] qb [3] = '{32'd6, 32'd20, 32'd200};

    initial begin
        #200000;
        $display("FAIL global_timeout simulation did not finish");
        $fatal(1, "global timeout");
    end

    initial begin
        int pi, ri, last, cyc, n;
        bit rdy, saw_full, seen;

        rst = 1'b0; hang = 1'b0; spur = 1'b0;
        bus.in_valid = 1'b0; bus.in_a = '0; bus.in_b = '0; bus.out_ready = 1'b0;
        #12;
        chk("rst_count", count, 0);
        chk("rst_in_ready", bus.in_ready, 1);
        chk("rst_start", bus.add_start, 0);
        chk("rst_add_a", bus.add_a, 0);
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_out_res", bus.out_res, 0);
        chk("rst_err", err, 0);
        @(negedge clk) rst = 1'b1;
        step();

        bus.out_ready = 1'b1;
        single_op("op1", 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b1);
        single_op("op2", 32'h12345678, 32'h11111111, 32'h23456789, 1'b0);

        // Burst of six with in_valid held: FIFO fills, results every 7 cycles.
        pi = 0; ri = 0; last = 0; cyc = 0; saw_full = 0;
        bus.in_valid = 1'b1; bus.in_a = ta[0]; bus.in_b = tb_[0];
        while (ri < 6 && cyc < 100) begin
            rdy = bus.in_ready;
            if (count == 3'd4) begin
                saw_full = 1;
                chk("burst_full_in_ready", bus.in_ready, 0);
            end
            if (bus.out_valid) begin
                chk("burst_res", bus.out_res, tr[ri]);
                chk("burst_ovf", bus.out_overflow, to[ri]);
                if (ri > 0) chk("burst_spacing", cyc - last, 7);
                last = cyc;
                ri++;
            end
            step(); cyc++;
            if (bus.in_valid && rdy) begin
                pi++;
                if (pi < 6) begin bus.in_a = ta[pi]; bus.in_b = tb_[pi]; end
                else bus.in_valid = 1'b0;
            end
        end
        chk("burst_all_results", ri, 6);
        chk("burst_saw_full", saw_full, 1);
        chk("burst_count_empty", count, 0);

        // Consumer stalls with three queued: first result held, nothing issues.
        bus.out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            bus.in_valid = 1'b1; bus.in_a = qa[i]; bus.in_b = qb[i];
            step();
        end
        bus.in_valid = 1'b0;
        n = 0;
        while (!bus.out_valid && n < 20) begin step(); n++; end
        repeat (6) begin
            chk("hold_valid", bus.out_valid, 1);
            chk("hold_res", bus.out_res, 32'd11);
            chk("hold_no_start", bus.add_start, 0);
            chk("hold_count", count, 2);
            step();
        end
        bus.out_ready = 1'b1;
        seen = 0;
        repeat (2) begin step(); if (bus.add_start) seen = 1; end
        chk("release_issue", seen, 1);
        wait_result("hold2", 32'd30, 1'b0);
        wait_result("hold3", 32'd300, 1'b0);

        // Hung adder: err rises exactly 15 cycles after entering WAIT.
        hang = 1'b1;
        bus.in_valid = 1'b1; bus.in_a = 32'd1; bus.in_b = 32'd1;
        step();
        bus.in_a = 32'd2; bus.in_b = 32'd3;
        step();
        bus.in_valid = 1'b0;
        chk("tmo_issue", bus.add_start, 1);
        step();
        for (int i = 0; i < 14; i++) begin
            chk("tmo_err_low", err, 0);
            chk("tmo_no_valid", bus.out_valid, 0);
            step();
        end
        chk("tmo_err_low_last", err, 0);
        step();
        chk("tmo_err_high", err, 1);
        chk("tmo_dropped", bus.out_valid, 0);
        hang = 1'b0;
        wait_result("tmo_next", 32'd5, 1'b0);
        chk("tmo_err_sticky", err, 1);

        // Spurious adder ready while idle.
        spur = 1'b1;
        step();
        spur = 1'b0;
        step();
        chk("spur_no_valid", bus.out_valid, 0);
        chk("spur_res_kept", bus.out_res, 32'd5);

        // Asynchronous reset in the middle of WAIT with two entries queued.
        for (int i = 0; i < 3; i++) begin
            bus.in_valid = 1'b1; bus.in_a = 32'(i + 1); bus.in_b = 32'(i + 1);
            step();
        end
        bus.in_valid = 1'b0;
        step();
        chk("mid_count", count, 2);
        #2 rst = 1'b0;
        #1;
        chk("arst_count", count, 0);
        chk("arst_in_ready", bus.in_ready, 1);
        chk("arst_start", bus.add_start, 0);
        chk("arst_add_a", bus.add_a, 0);
        chk("arst_add_b", bus.add_b, 0);
        chk("arst_out_valid", bus.out_valid, 0);
        chk("arst_out_res", bus.out_res, 0);
        chk("arst_err", err, 0);
        @(negedge clk) rst = 1'b1;
        repeat (8) begin
            step();
            chk("post_rst_no_start", bus.add_start, 0);
            chk("post_rst_count", count, 0);
        end
        bus.in_valid = 1'b1; bus.in_a = 32'd7; bus.in_b = 32'd8;
        step();
        bus.in_valid = 1'b0;
        wait_result("post_rst_op", 32'd15, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
